ace_rle_loader: RTL
===================

Name: ace_rle_loader

Overview:
- Streaming decoder for Jupiter Ace .ACE snapshot files delivered by hps_io over the ioctl byte interface.
- Expands the Z80-style RLE stream (ED-escaped runs) into sequential byte writes for the ace core's RAM, starting at 0x2000.
- Sits between hps_io (upstream) and the ace memory write port (downstream).
- Throttles hps_io with ioctl_wait while a run is being expanded, and holds the CPU in reset for the whole load.

Parameters:
- BASE_ADDR, 16'h2000, first RAM address written.
- ESC_BYTE, 8'hED, escape byte introducing a run.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  synchronous, active-high.
- ioctl_download  in  1  download active (hps_io).
- ioctl_index  in  8  file index; nonzero selects the ACE loader.
- ioctl_wr  in  1  byte strobe, single-cycle.
- ioctl_dout  in  8  byte data.
- ioctl_wait  out  1  stalls hps_io while high.
- loader_addr  out  16  RAM write address.
- loader_data  out  8  RAM write data.
- loader_wr  out  1  single-cycle RAM write strobe.
- loader_en  out  1  loader owns the RAM bus.
- loader_reset  out  1  CPU reset request.
- done  out  1  end marker (ED 00) was decoded; sticky until the next download.
- overflow  out  1  a write was attempted past 0xFFFF; sticky until the next download.

Behaviour:
- Reset values:
  - All outputs are 0.
  - loader_addr is BASE_ADDR.
  - State is IDLE.
- Gating: only bytes arriving with ioctl_index != 0 are processed.
- Download start:
  - Trigger is a rising edge of ioctl_download with ioctl_index != 0, taking effect the next cycle.
  - Loads addr = BASE_ADDR and clears done and overflow.
  - Sets loader_en = 1 and enters state LIT.
  - This also applies mid-operation: any run in progress is abandoned.
- loader_reset is high whenever loader_en is high.
- States: IDLE, LIT, CNT, VAL, RUN, END.
- LIT state:
  - Byte == ESC_BYTE: go to CNT.
  - Any other byte: issue one write (loader_wr = 1 the cycle after ioctl_wr, loader_data = byte); addr increments the cycle after the write.
- CNT state:
  - Byte == 0: go to END and set done.
  - Byte N in 1..255: latch count = N and go to VAL.
- VAL state:
  - Latch value V.
  - Assert ioctl_wait in the same cycle ioctl_wr is sampled.
  - Go to RUN.
- RUN state:
  - Issue one write per cycle of V at consecutive addresses, N writes total.
  - On the cycle after the last write: drop ioctl_wait and return to LIT.
  - Latency: the first write comes 1 cycle after the value byte; the run occupies N cycles.
  - "ED 01 ED" therefore produces a literal ED.
- END state: all further bytes are ignored and no writes occur; ioctl_wait stays 0.
- ioctl_wr arriving during RUN: a protocol violation by hps_io. The byte is dropped and the FSM is unaffected.
- Address boundary:
  - A write attempted when addr == 16'hFFFF after a prior write at 16'hFFFF (i.e. wrap) is suppressed and sets overflow.
  - addr never wraps to 0x0000; subsequent writes are suppressed.
- Download end (falling edge of ioctl_download):
  - If in RUN, the run completes first.
  - Then loader_en = 0, ioctl_wait = 0, state = IDLE.
  - done and overflow hold their values.
- reset: takes priority over everything, including mid-run; all outputs return to their reset values in the next cycle.

Optional Feature:
- Macro: ACE_LOADER_CHECKSUM_EN.
- With the macro defined, two extra outputs are present:
  - checksum [7:0]: XOR of every byte actually written.
  - wr_count [15:0]: number of writes performed.
  - Both clear at download start and at reset, and update in the same cycle as loader_wr.
- Without the macro, these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package ace_loader_pkg holds:
  - The state enum (IDLE, LIT, CNT, VAL, RUN, END).
  - The constants ACE_BASE_ADDR = 16'h2000 and ACE_ESC = 8'hED.
- One sub-module is natural: ace_rle_run_gen. It holds the count/value and address-increment engine that produces loader_wr and loader_addr, with start, busy and last handshakes. The top level keeps the parse FSM and the download edge logic.

Test Plan:
- Download bytes 11 22 33 -> writes 11@2000, 22@2001, 33@2002; done = 0; loader_en falls after download ends.
- Bytes ED 04 AA 55 -> four writes of AA at 2000..2003, then 55@2004; ioctl_wait high for exactly the 4 run cycles.
- Bytes ED 01 ED 77 ED 00 99 -> ED@2000, 77@2001, done = 1, 99 ignored with no write.
- Start at addr FFFE; bytes ED 05 01 -> writes at FFFE and FFFF only, then overflow = 1 and no write at 0000.
- reset asserted during a run of ED FF 00 after 10 writes -> next cycle loader_wr = 0, ioctl_wait = 0, loader_en = 0, state = IDLE.
- With ACE_LOADER_CHECKSUM_EN, bytes 0F ED 02 F0 -> checksum = 0F^F0^F0 = 0F, wr_count = 3.

Source files
------------

// File: rtl/ace_rle_loader_pkg.sv
// Shared types and constants for the Jupiter Ace .ACE snapshot loader.
package ace_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LIT,
        CNT,
        VAL,
        RUN,
        END
    } ace_state_e;

    localparam logic [15:0] ACE_BASE_ADDR = 16'h2000;
    localparam logic [7:0]  ACE_ESC       = 8'hED;

endpackage

// File: rtl/ace_rle_loader_if.sv
// hps_io ioctl byte-download bus. hps_io is the master, the loader the slave.
interface ace_rle_loader_if;

    logic       ioctl_download;
    logic [7:0] ioctl_index;
    logic       ioctl_wr;
    logic [7:0] ioctl_dout;
    logic       ioctl_wait;

    modport master (
        output ioctl_download,
        output ioctl_index,
        output ioctl_wr,
        output ioctl_dout,
        input  ioctl_wait
    );

    modport slave (
        input  ioctl_download,
        input  ioctl_index,
        input  ioctl_wr,
        input  ioctl_dout,
        output ioctl_wait
    );

endinterface

// File: rtl/ace_rle_loader_run_gen.sv
// Write engine: emits cnt consecutive writes of one value, advancing the
// address after each write and refusing to go past 0xFFFF.
// Optional ACE_LOADER_CHECKSUM_EN adds checksum/wr_count outputs.
module ace_rle_run_gen
    import ace_loader_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = ACE_BASE_ADDR
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        init,
    input  logic        start,
    input  logic [7:0]  start_cnt,
    input  logic [7:0]  start_val,
    output logic        busy,
    output logic        last,
    output logic        wr,
    output logic [15:0] addr,
    output logic [7:0]  data,
    output logic        ovf_evt
`ifdef ACE_LOADER_CHECKSUM_EN
    ,
    output logic [7:0]  checksum,
    output logic [15:0] wr_count
`endif
);

    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  val_q, val_d;
    logic [15:0] addr_q, addr_d;
    logic        full_q, full_d;

    assign busy    = (cnt_q != 8'd0);
    assign last    = (cnt_q == 8'd1);
    // Once 0xFFFF has been written, every further attempt is swallowed.
    assign wr      = busy && !full_q;
    assign ovf_evt = busy && full_q;
    assign addr    = addr_q;
    assign data    = val_q;

    // Next count/value/address; a start may land on the last write of the previous burst.
    always_comb begin
        cnt_d  = cnt_q;
        val_d  = val_q;
        addr_d = addr_q;
        full_d = full_q;
        if (busy) begin
            cnt_d = cnt_q - 8'd1;
            if (!full_q) begin
                if (addr_q == 16'hFFFF) begin
                    full_d = 1'b1;
                end else begin
                    addr_d = addr_q + 16'd1;
                end
            end
        end
        if (start) begin
            cnt_d = start_cnt;
            val_d = start_val;
        end
        if (init) begin
            cnt_d  = 8'd0;
            addr_d = BASE_ADDR;
            full_d = 1'b0;
        end
    end

    // Engine registers.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cnt_q  <= 8'd0;
            val_q  <= 8'd0;
            addr_q <= BASE_ADDR;
            full_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            val_q  <= val_d;
            addr_q <= addr_d;
            full_q <= full_d;
        end
    end

`ifdef ACE_LOADER_CHECKSUM_EN
    logic [7:0]  acc_q, acc_d;
    logic [15:0] num_q, num_d;

    // Outputs already include the write in progress, so they move with loader_wr.
    assign checksum = acc_q ^ (wr ? val_q : 8'h00);
    assign wr_count = num_q + {15'd0, wr};

    // Fold the current write into the running totals.
    always_comb begin
        acc_d = checksum;
        num_d = wr_count;
        if (init) begin
            acc_d = 8'h00;
            num_d = 16'd0;
        end
    end

    // Checksum registers.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            acc_q <= 8'h00;
            num_q <= 16'd0;
        end else begin
            acc_q <= acc_d;
            num_q <= num_d;
        end
    end
`endif

endmodule

// File: rtl/ace_rle_loader.sv
// Jupiter Ace .ACE snapshot loader: decodes the ED-escaped RLE byte stream
// from hps_io into sequential RAM writes starting at BASE_ADDR.
// Optional feature macro: ACE_LOADER_CHECKSUM_EN (adds checksum, wr_count).
module ace_rle_loader
    import ace_loader_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = ACE_BASE_ADDR,
    parameter logic [7:0]  ESC_BYTE  = ACE_ESC
) (
    input  logic            clk_sys,
    input  logic            reset,
    ace_rle_loader_if.slave ioctl,
    output logic [15:0]     loader_addr,
    output logic [7:0]      loader_data,
    output logic            loader_wr,
    output logic            loader_en,
    output logic            loader_reset,
    output logic            done,
    output logic            overflow
`ifdef ACE_LOADER_CHECKSUM_EN
    ,
    output logic [7:0]      checksum,
    output logic [15:0]     wr_count
`endif
);

    ace_state_e state_q, state_d;
    logic       dl_q;
    logic       en_q, en_d;
    logic       done_q, done_d;
    logic       ovf_q, ovf_d;
    logic [7:0] cnt_q, cnt_d;
    logic       end_pend_q, end_pend_d;

    logic       byte_ok, dl_rise, dl_fall, end_req, run_live;
    logic       gen_init, gen_start, gen_busy, gen_last, gen_ovf;
    logic [7:0] gen_cnt, gen_val;

    assign byte_ok = ioctl.ioctl_wr && (ioctl.ioctl_index != 8'd0);
    assign dl_rise = ioctl.ioctl_download && !dl_q && (ioctl.ioctl_index != 8'd0);
    assign dl_fall = dl_q && !ioctl.ioctl_download;
    // A download end is held off while a multi-write run still has writes left.
    assign end_req  = dl_fall || end_pend_q;
    assign run_live = gen_busy && !gen_last;

    assign ioctl.ioctl_wait = (state_q == RUN);
    assign loader_en        = en_q;
    assign loader_reset     = en_q;
    assign done             = done_q;
    assign overflow         = ovf_q;

    // Parse FSM: download start/end handling and byte classification.
    always_comb begin
        state_d    = state_q;
        en_d       = en_q;
        done_d     = done_q;
        ovf_d      = ovf_q;
        cnt_d      = cnt_q;
        end_pend_d = end_pend_q;
        gen_init   = 1'b0;
        gen_start  = 1'b0;
        gen_cnt    = 8'd1;
        gen_val    = ioctl.ioctl_dout;
        if (gen_ovf) begin
            ovf_d = 1'b1;
        end
        if (dl_rise) begin
            state_d    = LIT;
            en_d       = 1'b1;
            done_d     = 1'b0;
            ovf_d      = 1'b0;
            end_pend_d = 1'b0;
            gen_init   = 1'b1;
        end else if (end_req && !run_live) begin
            state_d    = IDLE;
            en_d       = 1'b0;
            end_pend_d = 1'b0;
        end else begin
            if (end_req) begin
                end_pend_d = 1'b1;
            end
            case (state_q)
                LIT: begin
                    if (byte_ok) begin
                        if (ioctl.ioctl_dout == ESC_BYTE) begin
                            state_d = CNT;
                        end else begin
                            gen_start = 1'b1;
                        end
                    end
                end
                CNT: begin
                    if (byte_ok) begin
                        if (ioctl.ioctl_dout == 8'd0) begin
                            state_d = END;
                            done_d  = 1'b1;
                        end else begin
                            cnt_d   = ioctl.ioctl_dout;
                            state_d = VAL;
                        end
                    end
                end
                VAL: begin
                    if (byte_ok) begin
                        gen_start = 1'b1;
                        gen_cnt   = cnt_q;
                        state_d   = RUN;
                    end
                end
                RUN: begin
                    // Bytes strobed here ignore ioctl_wait and are dropped.
                    if (gen_last) begin
                        state_d = LIT;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // FSM and control registers.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= IDLE;
            dl_q       <= 1'b0;
            en_q       <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            cnt_q      <= 8'd0;
            end_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dl_q       <= ioctl.ioctl_download;
            en_q       <= en_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            cnt_q      <= cnt_d;
            end_pend_q <= end_pend_d;
        end
    end

    ace_rle_run_gen #(
        .BASE_ADDR (BASE_ADDR)
    ) u_run_gen (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .init      (gen_init),
        .start     (gen_start),
        .start_cnt (gen_cnt),
        .start_val (gen_val),
        .busy      (gen_busy),
        .last      (gen_last),
        .wr        (loader_wr),
        .addr      (loader_addr),
        .data      (loader_data),
        .ovf_evt   (gen_ovf)
`ifdef ACE_LOADER_CHECKSUM_EN
        ,
        .checksum  (checksum),
        .wr_count  (wr_count)
`endif
    );

endmodule
